ahb_sram_if: RTL

AHB_SRAM_IF -- requirements
Module: ahb_sram_if

---
 rtl/ahb_sram_pkg.sv | 38 +++
 rtl/ahb_lane_dec.sv | 40 ++++
 rtl/ahb_sram_if.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ahb_sram_pkg.sv
// AHB-Lite to byte-lane SRAM bridge: shared encodings,
// FSM state type and default geometry.
package ahb_sram_pkg;

  localparam int MEM_DEPTH_DEF = 8192;
  localparam int NUM_BANKS_DEF = 4;
  localparam int BITW_DEF      = $clog2(MEM_DEPTH_DEF);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_DATA,
    RD_WAIT,
    ERR1,
    ERR2
  } state_e;

  function automatic logic [31:0] lane_bits(
    input logic [3:0] m
  );
    return {{8{m[3]}}, {8{m[2]}},
            {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/ahb_lane_dec.sv
// Byte-lane mask and alignment check for one
// AHB transfer (size plus low address bits).
module ahb_lane_dec
  import ahb_sram_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] haddr_i,
  output logic [3:0] mask_o,
  output logic       err_o
);

  always_comb begin
    mask_o = 4'b0000;
    err_o  = 1'b0;
    unique case (hsize_i)
      HSIZE_BYTE: begin
        mask_o = 4'b0001 << haddr_i;
      end
      HSIZE_HALF: begin
        if (haddr_i[0]) begin
          err_o = 1'b1;
        end else begin
          mask_o = haddr_i[1] ? 4'b1100
                              : 4'b0011;
        end
      end
      HSIZE_WORD: begin
        if (haddr_i != 2'b00) begin
          err_o = 1'b1;
        end else begin
          mask_o = 4'b1111;
        end
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave bridging to four byte-lane SRAM
// banks with registered read data.
module ahb_sram_if
  import ahb_sram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int BITW      = $clog2(MEM_DEPTH),
  parameter int NUM_BANKS = NUM_BANKS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [31:0]          haddr,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic [NUM_BANKS-1:0] sram_csn,
  output logic                 sram_we,
  output logic [BITW-1:0]      sram_addr,
  output logic [31:0]          sram_din,
  input  logic [31:0]          sram_dout
);

  state_e          state_q, state_d;
  logic [BITW-1:0] addr_q, addr_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      dec_mask;
  logic            dec_err;
  logic            accept;
  logic            unused_bits;

  assign unused_bits = ^{haddr[31:BITW+2],
                         htrans[0]};

  ahb_lane_dec u_lane_dec (
    .hsize_i (hsize),
    .haddr_i (haddr[1:0]),
    .mask_o  (dec_mask),
    .err_o   (dec_err)
  );

  assign accept = hsel & hready & htrans[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    sram_csn  = '1;
    sram_we   = 1'b0;
    sram_addr = haddr[BITW+1:2];
    sram_din  = hwdata;
    unique case (state_q)
      RD_WAIT: begin
        hreadyout = 1'b0;
        sram_csn  = ~mask_q;
        sram_addr = addr_q;
        state_d   = RD_DATA;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ERR2;
      end
      default: begin
        hresp = (state_q == ERR2);
        if (state_q == RD_DATA) begin
          hrdata = sram_dout & lane_bits(mask_q);
        end
        // A pending write owns the bank this cycle
        if (state_q == WR_DATA) begin
          sram_we   = 1'b1;
          sram_csn  = ~mask_q;
          sram_addr = addr_q;
        end
        state_d = IDLE;
        if (accept) begin
          addr_d = haddr[BITW+1:2];
          mask_d = dec_mask;
          if (dec_err) begin
            state_d = ERR1;
          end else if (hwrite) begin
            state_d = WR_DATA;
          end else if (state_q == WR_DATA) begin
            state_d = RD_WAIT;
          end else begin
            state_d  = RD_DATA;
            sram_csn = ~dec_mask;
          end
        end
      end
    endcase
    // Pending work is dropped, never issued
    if (rst) begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      hrdata    = '0;
      sram_csn  = '1;
      sram_we   = 1'b0;
    end
  end

endmodule
